risc_seq_ctrl: RTL and testbench
================================

Name: risc_seq_ctrl

Overview:
Multi-cycle sequencer for the basic RISC datapath. It generates the load enables for the enabled-register instances (PC, IR, ACC) and the memory handshake strobes. It walks fetch/decode/execute per instruction, waits on a memory-ready handshake, and flags a sticky error if memory stalls too long. It sits beside the datapath and is the only driver of every register EN.

Parameters:
WAIT_MAX, 15, maximum cycles allowed in a memory wait state before error (1..255)
OP_WIDTH, 3, opcode width; fixed at 3 for this ISA, not to be overridden

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  one-cycle pulse; leaves IDLE or HALT
OPCODE  input  OP_WIDTH  opcode field from IR output
ZERO  input  1  accumulator-zero flag from datapath
MEM_RDY  input  1  memory completes current read/write this cycle
IR_EN  output  1  IR register enable
PC_EN  output  1  PC register enable
PC_LOAD  output  1  PC mux: 1 = IR operand (jump), 0 = PC+1
ACC_EN  output  1  accumulator enable
ADDR_SEL  output  1  address mux: 0 = PC, 1 = IR operand
MEM_RD  output  1  memory read strobe
MEM_WR  output  1  memory write strobe
HALTED  output  1  high in HALT state
ERR  output  1  sticky memory-timeout error

Behaviour:
- Reset (async, RST_N=0): state=IDLE, wait counter=0; all outputs 0. Reset mid-instruction aborts it with no further enables.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- States and transitions:
  - IDLE: START→FETCH.
  - FETCH: ADDR_SEL=0, MEM_RD=1; IR_EN=MEM_RDY (Mealy); MEM_RDY→DECODE.
  - DECODE: PC_EN=1, PC_LOAD=0 (PC+1); →EXEC.
  - EXEC, by OPCODE:
    - HLT→HALT.
    - SKZ: PC_EN=ZERO →FETCH.
    - JMP: PC_EN=1, PC_LOAD=1 →FETCH.
    - ADD/AND/XOR/LDA→MEMRD.
    - STO→MEMWR.
  - MEMRD: ADDR_SEL=1, MEM_RD=1; MEM_RDY→WB.
  - WB: ACC_EN=1 →FETCH.
  - MEMWR: ADDR_SEL=1, MEM_WR=1; MEM_RDY→FETCH.
  - HALT: HALTED=1; START→FETCH (resume at current PC).
  - ERR: ERR=1, all enables/strobes 0; exit only by reset.
- Outputs not listed for a state are 0. Outputs are decoded from the state register; IR_EN also depends on MEM_RDY.
- Wait counter, used in FETCH, MEMRD and MEMWR:
  - Clears on entry to a wait state and when MEM_RDY=1.
  - Increments each cycle MEM_RDY=0.
  - When the counter equals WAIT_MAX-1 and MEM_RDY=0 → ERR next cycle. MEM_RDY on that same cycle wins (normal transition).
- Latency with MEM_RDY tied 1:
  - LDA/ADD/AND/XOR: 5 cycles.
  - STO: 4 cycles.
  - JMP/SKZ: 3 cycles.
  - HLT: 3 cycles to HALT.
- START outside IDLE/HALT is ignored. START and MEM_RDY together in FETCH: MEM_RDY governs.
- OPCODE is sampled only in EXEC; changes in other states have no effect.

Decomposition:
- Package risc_ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEMRD, WB, MEMWR, HALT, ERR), 4-bit encoding.
  - opcode localparams.
  - OP_WIDTH constant.
- Sub-module mem_wait_timer (params WAIT_MAX; ports CLK, RST_N, CLR, RUN, EXPIRE): holds the wait counter. The FSM stays in risc_seq_ctrl.

Test Plan:
- Reset, START, OPCODE=LDA, MEM_RDY=1 → states FETCH,DECODE,EXEC,MEMRD,WB. IR_EN in cycle 1, PC_EN in cycle 2, ADDR_SEL=1+MEM_RD in cycle 4, ACC_EN in cycle 5, back in FETCH at cycle 6.
- OPCODE=SKZ, ZERO=1 → PC_EN high in DECODE and EXEC (2 increments). With ZERO=0 → PC_EN only in DECODE.
- OPCODE=JMP → PC_EN=PC_LOAD=1 in EXEC. OPCODE=STO with MEM_RDY low 3 cycles → MEM_WR held 4 cycles, ADDR_SEL=1, then FETCH.
- WAIT_MAX=15, MEM_RDY=0 in FETCH → ERR=1 after 15 wait cycles, all strobes 0. START has no effect; RST_N low clears ERR.
- MEM_RDY rises on the 15th wait cycle → no ERR, normal transition.
- OPCODE=HLT → HALTED=1 and held. START pulse → FETCH next cycle. RST_N pulsed low mid-MEMRD → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/risc_seq_ctrl_pkg.sv
// Shared types and constants for the RISC multi-cycle sequencer.
// The opcode width is fixed by the ISA, so it lives here rather than as a module parameter.
package risc_ctrl_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_WB     = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_HALT   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_HLT = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_SKZ = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_LDA = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_STO = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_JMP = 3'd7;

  // States that sit on the memory handshake and are guarded by the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/risc_seq_ctrl_if.sv
// Datapath/memory-facing signal bundle of the sequencer.
// master = datapath side (drives status in), slave = sequencer (drives enables out).
interface risc_seq_ctrl_if;
  import risc_ctrl_pkg::*;

  logic                START;
  logic [OP_WIDTH-1:0] OPCODE;
  logic                ZERO;
  logic                MEM_RDY;
  logic                IR_EN;
  logic                PC_EN;
  logic                PC_LOAD;
  logic                ACC_EN;
  logic                ADDR_SEL;
  logic                MEM_RD;
  logic                MEM_WR;
  logic                HALTED;
  logic                ERR;

  modport master (
    output START, OPCODE, ZERO, MEM_RDY,
    input  IR_EN, PC_EN, PC_LOAD, ACC_EN, ADDR_SEL, MEM_RD, MEM_WR, HALTED, ERR
  );

  modport slave (
    input  START, OPCODE, ZERO, MEM_RDY,
    output IR_EN, PC_EN, PC_LOAD, ACC_EN, ADDR_SEL, MEM_RD, MEM_WR, HALTED, ERR
  );

endinterface

// File: rtl/risc_seq_ctrl_mem_wait_timer.sv
// Memory wait-state watchdog: counts stalled cycles and flags the last allowed one.
// EXPIRE is combinational so the sequencer can leave for ERR on the following edge.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  input  logic RUN,
  output logic EXPIRE
);

  localparam logic [7:0] TERM_CNT = 8'(WAIT_MAX - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= 8'd0;
    end else if (CLR) begin
      cnt_q <= 8'd0;
    end else if (RUN) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign EXPIRE = RUN && (cnt_q == TERM_CNT);

endmodule

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer; sole driver of the datapath register enables.
//
//   state  | meaning
//   IDLE   | after reset, waiting for START
//   FETCH  | read instruction at PC, IR_EN when memory ready
//   DECODE | PC <= PC+1
//   EXEC   | act on OPCODE (skip, jump, halt, or go to memory)
//   MEMRD  | read operand at IR address
//   WB     | load accumulator
//   MEMWR  | write accumulator to IR address
//   HALT   | parked, START resumes at current PC
//   ERR    | memory timeout, left only through reset
module risc_seq_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST_N,
  risc_seq_ctrl_if.slave   bus
);

  state_t state_q;
  state_t state_d;
  logic   in_wait;
  logic   tmr_clr;
  logic   tmr_run;
  logic   tmr_expire;

  // Counter is held at zero outside wait states, which gives the clear-on-entry behaviour.
  assign in_wait = is_wait_state(state_q);
  assign tmr_run = in_wait && !bus.MEM_RDY;
  assign tmr_clr = !in_wait || bus.MEM_RDY;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CLR    (tmr_clr),
    .RUN    (tmr_run),
    .EXPIRE (tmr_expire)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.IR_EN    = 1'b0;
    bus.PC_EN    = 1'b0;
    bus.PC_LOAD  = 1'b0;
    bus.ACC_EN   = 1'b0;
    bus.ADDR_SEL = 1'b0;
    bus.MEM_RD   = 1'b0;
    bus.MEM_WR   = 1'b0;
    bus.HALTED   = 1'b0;
    bus.ERR      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        bus.MEM_RD = 1'b1;
        bus.IR_EN  = bus.MEM_RDY;
        if (bus.MEM_RDY)     state_d = ST_DECODE;
        else if (tmr_expire) state_d = ST_ERR;
      end

      ST_DECODE: begin
        bus.PC_EN = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        case (bus.OPCODE)
          OP_HLT: state_d = ST_HALT;
          OP_SKZ: begin
            bus.PC_EN = bus.ZERO;
            state_d   = ST_FETCH;
          end
          OP_JMP: begin
            bus.PC_EN   = 1'b1;
            bus.PC_LOAD = 1'b1;
            state_d     = ST_FETCH;
          end
          OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = ST_MEMRD;
          OP_STO: state_d = ST_MEMWR;
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEMRD: begin
        bus.ADDR_SEL = 1'b1;
        bus.MEM_RD   = 1'b1;
        if (bus.MEM_RDY)     state_d = ST_WB;
        else if (tmr_expire) state_d = ST_ERR;
      end

      ST_WB: begin
        bus.ACC_EN = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEMWR: begin
        bus.ADDR_SEL = 1'b1;
        bus.MEM_WR   = 1'b1;
        if (bus.MEM_RDY)     state_d = ST_FETCH;
        else if (tmr_expire) state_d = ST_ERR;
      end

      ST_HALT: begin
        bus.HALTED = 1'b1;
        if (bus.START) state_d = ST_FETCH;
      end

      ST_ERR: begin
        bus.ERR = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Randomized instruction-level bench for risc_seq_ctrl with a per-cycle expected-output scoreboard.
module tb_risc_seq_ctrl;
  import risc_ctrl_pkg::*;

  localparam int WAIT_MAX = 15;

  // Expected-output bit positions: {IR_EN,PC_EN,PC_LOAD,ACC_EN,ADDR_SEL,MEM_RD,MEM_WR,HALTED,ERR}
  localparam logic [8:0] E_IR  = 9'h100;
  localparam logic [8:0] E_PC  = 9'h080;
  localparam logic [8:0] E_PCL = 9'h040;
  localparam logic [8:0] E_ACC = 9'h020;
  localparam logic [8:0] E_AS  = 9'h010;
  localparam logic [8:0] E_RD  = 9'h008;
  localparam logic [8:0] E_WR  = 9'h004;
  localparam logic [8:0] E_HLT = 9'h002;
  localparam logic [8:0] E_ERR = 9'h001;

  logic CLK = 1'b0;
  logic RST_N;

  risc_seq_ctrl_if bus();

  risc_seq_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [8:0] act;
  assign act = {bus.IR_EN, bus.PC_EN, bus.PC_LOAD, bus.ACC_EN, bus.ADDR_SEL,
                bus.MEM_RD, bus.MEM_WR, bus.HALTED, bus.ERR};

  logic [8:0] mon_exp;
  string      mon_tag;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      checks++;
      if (act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (t=%0t)", mon_tag, act, mon_exp, $time);
      end
    end
  end

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input bit rst, input bit st, input logic [2:0] op, input bit z,
                     input bit rdy, input logic [8:0] e, input string t);
    @(posedge CLK);
    #1;
    RST_N       = rst;
    bus.START   = st;
    bus.OPCODE  = op;
    bus.ZERO    = z;
    bus.MEM_RDY = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // kind: 0 = instruction fetch, 1 = operand read, 2 = operand write
  function automatic logic [8:0] mem_exp(input int kind, input bit rdy);
    case (kind)
      0:       return E_RD | (rdy ? E_IR : 9'h000);
      1:       return E_AS | E_RD;
      default: return E_AS | E_WR;
    endcase
  endfunction

  task automatic mem_phase(input int kind, input int waits, input string t);
    for (int i = 0; i < waits; i++) cyc(1, rbit(), rop(), rbit(), 0, mem_exp(kind, 0), t);
    cyc(1, rbit(), rop(), rbit(), 1, mem_exp(kind, 1), t);
  endtask

  function automatic logic [8:0] exec_exp(input logic [2:0] op, input bit z);
    if (op == OP_SKZ) return z ? E_PC : 9'h000;
    if (op == OP_JMP) return E_PC | E_PCL;
    return 9'h000;
  endfunction

  task automatic run_instr(input logic [2:0] op, input bit z, input int fw, input int mw);
    mem_phase(0, fw, "fetch");
    cyc(1, rbit(), rop(), rbit(), rbit(), E_PC, "decode");
    cyc(1, rbit(), op, z, rbit(), exec_exp(op, z), "exec");
    if (op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA}) begin
      mem_phase(1, mw, "memrd");
      cyc(1, rbit(), rop(), rbit(), rbit(), E_ACC, "wb");
    end else if (op == OP_STO) begin
      mem_phase(2, mw, "memwr");
    end else if (op == OP_HLT) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++)
        cyc(1, 0, rop(), rbit(), rbit(), E_HLT, "halt_hold");
      cyc(1, 1, rop(), rbit(), rbit(), E_HLT, "halt_start");
    end
  endtask

  function automatic int rwait();
    if ($urandom_range(0, 7) == 0) return WAIT_MAX - 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic reset_and_start(input string t);
    cyc(0, rbit(), rop(), rbit(), rbit(), 9'h000, t);
    cyc(1, 0, rop(), rbit(), rbit(), 9'h000, "idle");
    cyc(1, 1, rop(), rbit(), rbit(), 9'h000, "idle_start");
  endtask

  initial begin
    RST_N       = 1'b0;
    bus.START   = 1'b0;
    bus.OPCODE  = '0;
    bus.ZERO    = 1'b0;
    bus.MEM_RDY = 1'b0;

    cyc(0, 0, 3'd0, 0, 0, 9'h000, "reset");
    cyc(0, 1, 3'd5, 1, 1, 9'h000, "reset_start");
    cyc(1, 0, rop(), rbit(), rbit(), 9'h000, "idle");
    cyc(1, 0, rop(), rbit(), rbit(), 9'h000, "idle");
    cyc(1, 1, rop(), rbit(), rbit(), 9'h000, "idle_start");

    // Directed instructions with zero memory wait
    run_instr(OP_LDA, 0, 0, 0);
    run_instr(OP_SKZ, 1, 0, 0);
    run_instr(OP_SKZ, 0, 0, 0);
    run_instr(OP_JMP, 0, 0, 0);
    run_instr(OP_STO, 0, 0, 3);
    run_instr(OP_HLT, 0, 0, 0);
    // Memory ready arrives on the last permitted wait cycle
    run_instr(OP_ADD, 0, WAIT_MAX - 1, WAIT_MAX - 1);
    run_instr(OP_STO, 1, 2, WAIT_MAX - 1);

    for (int n = 0; n < 40; n++) run_instr(rop(), rbit(), rwait(), rwait());

    // Fetch timeout: ERR is sticky and ignores START
    for (int i = 0; i < WAIT_MAX; i++) cyc(1, rbit(), rop(), rbit(), 0, E_RD, "fetch_timeout");
    for (int i = 0; i < 4; i++) cyc(1, rbit(), rop(), rbit(), rbit(), E_ERR, "err_sticky");
    reset_and_start("err_reset");

    // Operand write timeout
    run_instr(OP_XOR, 0, 1, 1);
    mem_phase(0, 0, "fetch");
    cyc(1, 0, rop(), rbit(), rbit(), E_PC, "decode");
    cyc(1, 0, OP_STO, rbit(), rbit(), 9'h000, "exec");
    for (int i = 0; i < WAIT_MAX; i++) cyc(1, rbit(), rop(), rbit(), 0, E_AS | E_WR, "memwr_timeout");
    cyc(1, 1, rop(), rbit(), 1, E_ERR, "err_sticky_wr");
    reset_and_start("err_reset_wr");

    // Reset in the middle of an operand read aborts with no enables
    mem_phase(0, 0, "fetch");
    cyc(1, 0, rop(), rbit(), rbit(), E_PC, "decode");
    cyc(1, 0, OP_LDA, rbit(), rbit(), 9'h000, "exec");
    cyc(1, 0, rop(), rbit(), 0, E_AS | E_RD, "memrd");
    cyc(1, 0, rop(), rbit(), 0, E_AS | E_RD, "memrd");
    cyc(0, 0, rop(), rbit(), 1, 9'h000, "rst_mid_memrd");
    cyc(1, 0, rop(), rbit(), 1, 9'h000, "post_rst_idle");
    cyc(1, 0, rop(), rbit(), 1, 9'h000, "post_rst_idle");
    cyc(1, 1, rop(), rbit(), rbit(), 9'h000, "idle_start");
    run_instr(OP_AND, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
